// File: rtl/fa_post_norm.sv
// Floating-point adder post-normalisation: sum formation + leading-zero count, then normalise/round/pack.
// Optional macro FA_RNE_ROUND_EN selects round-to-nearest-even on the carry-out add path (default: truncate).
module fa_post_norm #(
    parameter int unsigned EXP_W = 8
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_ex,
    input  logic              in_yn,
    input  logic [24:0]       in_P0,
    input  logic [24:0]       in_GG,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [2:0]        out_flags
);

    localparam int unsigned SUM_W  = 25;
    localparam int unsigned MANT_W = 24;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned LZC_W  = 5;
    localparam int unsigned EXP1_W = EXP_W + 1;
    localparam int unsigned EXP_INF = (1 << EXP_W) - 1;

    logic                s1_valid;
    logic                s1_sign;
    logic [EXP_W-1:0]    s1_ex;
    logic                s1_yn;
    logic [SUM_W-1:0]    s1_sum;
    logic [LZC_W-1:0]    s1_lzc;
    logic                s2_valid;
    logic                s2_advance;

    logic [SUM_W-1:0]    sum_c;
    logic [LZC_W-1:0]    lzc_c;
    logic [EXP1_W-1:0]   exp_c;
    logic [MANT_W-1:0]   mant_c;
    logic [MANT_W:0]     mant_inc_c;
    logic                rnd_c;
    logic [31:0]         res_c;
    logic [2:0]          flags_c;
    logic                unused_bits;

    assign s2_advance = !s2_valid || out_ready;
    assign in_ready   = !s1_valid || s2_advance;
    assign out_valid  = s2_valid;
    assign unused_bits = ^{in_GG[SUM_W-1], s1_sum[0]};

    // Sum bit i is propagate xor the carry into bit i; yn is the carry into bit 0.
    assign sum_c = {in_P0[SUM_W-1:1] ^ in_GG[SUM_W-2:0], in_P0[0] ^ in_yn};

    always_comb begin
        lzc_c = LZC_W'(MANT_W);
        for (int i = 0; i < int'(MANT_W); i++) begin
            if (sum_c[i]) lzc_c = LZC_W'(int'(MANT_W) - 1 - i);
        end
    end

    // Normalise, round and pack the stage-1 contents.
    always_comb begin
        res_c      = '0;
        flags_c    = '0;
        exp_c      = '0;
        mant_c     = '0;
        mant_inc_c = '0;
        rnd_c      = 1'b0;
        if (s1_ex == EXP_W'(EXP_INF)) begin
            res_c   = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flags_c = 3'b100;
        end else if (!s1_yn && s1_sum[SUM_W-1]) begin
            mant_c = s1_sum[SUM_W-1:1];
            exp_c  = EXP1_W'(s1_ex) + EXP1_W'(1);
`ifdef FA_RNE_ROUND_EN
            rnd_c  = s1_sum[0] & s1_sum[1];
`else
            rnd_c  = 1'b0;
`endif
            mant_inc_c = {1'b0, mant_c} + (MANT_W+1)'(rnd_c);
            if (mant_inc_c[MANT_W]) begin
                mant_c = {1'b1, {FRAC_W{1'b0}}};
                exp_c  = exp_c + EXP1_W'(1);
            end else begin
                mant_c = mant_inc_c[MANT_W-1:0];
            end
            if (exp_c >= EXP1_W'(EXP_INF)) begin
                res_c   = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                flags_c = 3'b100;
            end else begin
                res_c   = {s1_sign, exp_c[EXP_W-1:0], mant_c[FRAC_W-1:0]};
            end
        end else if (s1_sum[MANT_W-1:0] == '0) begin
            res_c   = '0;
            flags_c = 3'b001;
        end else if (s1_ex <= EXP_W'(s1_lzc)) begin
            // No denormals: anything needing exponent <= 0 flushes to signed zero.
            res_c   = {s1_sign, {(EXP_W+FRAC_W){1'b0}}};
            flags_c = 3'b011;
        end else begin
            exp_c  = EXP1_W'(s1_ex) - EXP1_W'(s1_lzc);
            mant_c = s1_sum[MANT_W-1:0] << s1_lzc;
            res_c  = {s1_sign, exp_c[EXP_W-1:0], mant_c[FRAC_W-1:0]};
        end
    end

    // Stage 1: capture the raw sum and its leading-zero count.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_ex    <= '0;
            s1_yn    <= 1'b0;
            s1_sum   <= '0;
            s1_lzc   <= '0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_ready && in_valid) begin
                s1_sign <= in_sign;
                s1_ex   <= in_ex;
                s1_yn   <= in_yn;
                s1_sum  <= sum_c;
                s1_lzc  <= lzc_c;
            end
        end
    end

    // Stage 2: registered packed result.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s2_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= res_c;
                out_flags  <= flags_c;
            end
        end
    end

endmodule

// File: tb/tb_fa_post_norm.sv
// Bench for fa_post_norm: directed vector table, backpressure and reset sequences, random scoreboard run.
module tb_fa_post_norm;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_ex;
    logic        in_yn;
    logic [24:0] in_P0;
    logic [24:0] in_GG;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    int total = 0;
    int bad   = 0;
    logic        sb_en  = 1'b0;
    logic        held_v = 1'b0;
    logic [34:0] held;
    logic [34:0] exp_q[$];

    typedef struct {
        logic        sign;
        logic [7:0]  ex;
        logic        yn;
        logic [24:0] sum;
        logic [31:0] res;
        logic [2:0]  flg;
    } vec_t;

    localparam int NV = 13;
    vec_t vt[NV];

    fa_post_norm #(.EXP_W(8)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_ex(in_ex), .in_yn(in_yn),
        .in_P0(in_P0), .in_GG(in_GG),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: value-level IEEE packing from the sum, independent of pipeline structure.
    function automatic logic [34:0] ref_model(input logic sign, input logic [7:0] ex,
                                              input logic yn, input logic [24:0] p0,
                                              input logic [24:0] gg);
        logic [24:0] s;
        logic [23:0] lo;
        int unsigned m;
        int e;
        int lz;
        s = p0 ^ {gg[23:0], yn};
        if (ex == 8'hFF) return {3'b100, sign, 8'hFF, 23'd0};
        if (!yn && s[24]) begin
            m = 32'(s >> 1);
            e = int'(ex) + 1;
`ifdef FA_RNE_ROUND_EN
            if (s[0] && m[0]) m = m + 1;
`endif
            if (m == 32'h0100_0000) begin
                m = 32'h0080_0000;
                e = e + 1;
            end
            if (e >= 255) return {3'b100, sign, 8'hFF, 23'd0};
            return {3'b000, sign, 8'(e), m[22:0]};
        end
        lo = s[23:0];
        if (lo == 24'd0) return {3'b001, 32'd0};
        lz = 0;
        while (lz < 24 && lo[23-lz] == 1'b0) lz++;
        if (int'(ex) <= lz) return {3'b011, sign, 31'd0};
        m = 32'(lo) << lz;
        return {3'b000, sign, 8'(int'(ex) - lz), m[22:0]};
    endfunction

    task automatic encode(input logic [24:0] s, input logic yn,
                          output logic [24:0] p0, output logic [24:0] gg);
        p0       = 25'($urandom);
        p0[0]    = s[0] ^ yn;
        gg[23:0] = p0[24:1] ^ s[24:1];
        gg[24]   = 1'($urandom);
    endtask

    task automatic gen_rand();
        logic [24:0] s;
        int r;
        in_sign = 1'($urandom);
        in_yn   = 1'($urandom);
        s = 25'($urandom) >> $urandom_range(0, 25);
        if ($urandom_range(0, 15) == 0) s = 25'h1FFFFFF;
        if (!in_yn && s == 25'd0) s = 25'd1;
        r = $urandom_range(0, 9);
        case (r)
            0:       in_ex = 8'hFF;
            1:       in_ex = 8'hFE;
            2:       in_ex = 8'hFD;
            3:       in_ex = 8'($urandom_range(0, 8));
            default: in_ex = 8'($urandom_range(0, 255));
        endcase
        encode(s, in_yn, in_P0, in_GG);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        in_sign  = v.sign;
        in_ex    = v.ex;
        in_yn    = v.yn;
        encode(v.sum, v.yn, in_P0, in_GG);
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1 chk("vec_in_ready", 35'(in_ready), 35'd1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        chk("vec_lat_early", 35'(out_valid), 35'd0);
        @(posedge CLK); #1;
        chk("vec_lat_valid", 35'(out_valid), 35'd1);
        chk($sformatf("vec%0d", idx), {out_flags, out_result}, {v.flg, v.res});
    endtask

    // Scoreboard: pop before push so a same-cycle accept is never matched early.
    always @(negedge CLK) begin
        if (sb_en) begin
            if (held_v && out_valid) chk("stall_hold", {out_flags, out_result}, held);
            held_v = out_valid && !out_ready;
            held   = {out_flags, out_result};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_extra: actual=%h required=none", {out_flags, out_result});
                end else begin
                    chk("sb_result", {out_flags, out_result}, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(ref_model(in_sign, in_ex, in_yn, in_P0, in_GG));
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        vt[0]  = '{1'b0, 8'd127, 1'b0, 25'h1000000, 32'h40000000, 3'b000};
        vt[1]  = '{1'b0, 8'd127, 1'b1, 25'h0200000, 32'h3E800000, 3'b000};
        vt[2]  = '{1'b1, 8'd127, 1'b1, 25'h0000000, 32'h00000000, 3'b001};
        vt[3]  = '{1'b1, 8'd2,   1'b1, 25'h0040000, 32'h80000000, 3'b011};
        vt[4]  = '{1'b0, 8'd254, 1'b0, 25'h1000000, 32'h7F800000, 3'b100};
        vt[5]  = '{1'b1, 8'hFF,  1'b1, 25'h0123456, 32'hFF800000, 3'b100};
`ifdef FA_RNE_ROUND_EN
        vt[6]  = '{1'b0, 8'd100, 1'b0, 25'h1FFFFFF, 32'h33000000, 3'b000};
        vt[8]  = '{1'b0, 8'd253, 1'b0, 25'h1FFFFFF, 32'h7F800000, 3'b100};
        vt[12] = '{1'b0, 8'd127, 1'b0, 25'h1000003, 32'h40000002, 3'b000};
`else
        vt[6]  = '{1'b0, 8'd100, 1'b0, 25'h1FFFFFF, 32'h32FFFFFF, 3'b000};
        vt[8]  = '{1'b0, 8'd253, 1'b0, 25'h1FFFFFF, 32'h7F7FFFFF, 3'b000};
        vt[12] = '{1'b0, 8'd127, 1'b0, 25'h1000003, 32'h40000001, 3'b000};
`endif
        vt[7]  = '{1'b0, 8'd10,  1'b0, 25'h0C00000, 32'h05400000, 3'b000};
        vt[9]  = '{1'b0, 8'd0,   1'b1, 25'h0800000, 32'h00000000, 3'b011};
        vt[10] = '{1'b0, 8'd3,   1'b1, 25'h0200000, 32'h00800000, 3'b000};
        vt[11] = '{1'b0, 8'd127, 1'b0, 25'h1000001, 32'h40000000, 3'b000};

        RESETn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_sign = 1'b0; in_ex = '0; in_yn = 1'b0; in_P0 = '0; in_GG = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_valid", 35'(out_valid), 35'd0);
        chk("rst_out", {out_flags, out_result}, 35'd0);
        @(negedge CLK) RESETn = 1'b1;
        @(posedge CLK); #1;
        chk("rst_in_ready", 35'(in_ready), 35'd1);

        for (int i = 0; i < NV; i++) run_vec(vt[i], i);
        @(posedge CLK); #1;
        sb_en = 1'b1;

        // Backpressure: out_ready low for 3 cycles while inputs arrive back to back.
        for (int c = 0; c < 5; c++) begin
            if (c == 0 || in_ready) gen_rand();
            in_valid  = 1'b1;
            out_ready = (c >= 3);
            #1;
            if (c == 2) chk("bp_in_ready_low", 35'(in_ready), 35'd0);
            else        chk("bp_in_ready_high", 35'(in_ready), 35'd1);
            @(posedge CLK); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        while ((exp_q.size() != 0 || out_valid) && cnt < 20) begin
            @(posedge CLK); #1;
            cnt++;
        end
        chk("bp_drain", 35'(exp_q.size()), 35'd0);

        for (int n = 0; n < 600; n++) begin
            gen_rand();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge CLK); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        while ((exp_q.size() != 0 || out_valid) && cnt < 20) begin
            @(posedge CLK); #1;
            cnt++;
        end
        chk("rand_drain", 35'(exp_q.size()), 35'd0);
        sb_en = 1'b0;

        // Reset with two results in flight.
        gen_rand();
        in_valid = 1'b1;
        @(posedge CLK); #1;
        gen_rand();
        @(posedge CLK); #1;
        in_valid = 1'b0;
        chk("inflight_valid", 35'(out_valid), 35'd1);
        RESETn = 1'b0;
        #1;
        chk("midrst_valid", 35'(out_valid), 35'd0);
        chk("midrst_out", {out_flags, out_result}, 35'd0);
        @(posedge CLK); #1;
        chk("midrst_valid_hold", 35'(out_valid), 35'd0);
        @(negedge CLK) RESETn = 1'b1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (out_valid) cnt++;
        end
        chk("postrst_quiet", 35'(cnt), 35'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fa_post_norm.md
FA_POST_NORM -- requirements
Module: fa_post_norm

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width; only value 8 is supported.
REQ-002 SHALL have port CLK  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port RESETn  input  1  reset: asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  the prefix-adder result is present on the inputs this cycle.
REQ-005 SHALL have port in_ready  output  1  the block accepts the input this cycle.
REQ-006 SHALL have port in_sign  input  1  result sign.
REQ-007 SHALL have port in_ex  input  8  pre-normalisation exponent (biased).
REQ-008 SHALL have port in_yn  input  1  effective subtract; also carry-in to bit 0.
REQ-009 SHALL have port in_P0  input  25  bitwise propagate A^B.
REQ-010 SHALL have port in_GG  input  25  group generate; GG[i] is the carry out of bit i, including carry-in.
REQ-011 SHALL have port out_valid  output  1  out_result is valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_result.
REQ-013 SHALL have port out_result  output  32  IEEE-754 single-precision result.
REQ-014 SHALL have port out_flags  output  3  {overflow, underflow, zero}.

Function
REQ-015 Stage 1 SHALL compute sum[0]=P0[0]^in_yn and sum[i]=P0[i]^GG[i-1] for i=1..24, and lzc = count of leading zeros of sum[23:0] (0..24); it SHALL register sign, ex, yn, sum and lzc.
REQ-016 Stage 2 SHALL normalise, round and pack, and SHALL register out_result and out_flags.
REQ-017 Latency SHALL be exactly 2 cycles from in_valid&in_ready to out_valid when out_ready is held high; throughput SHALL be 1 result/cycle.
REQ-018 Each stage SHALL advance when it is empty or the stage after it advances; out_valid&!out_ready SHALL hold every stage and every output stable.
REQ-019 in_ready SHALL equal !s1_valid | s2_advance, and SHALL be combinational from out_ready.
REQ-020 Add path (yn=0) with sum[24]=1: mantissa=sum[24:1], exponent=ex+1, round bit=sum[0].
REQ-021 Add path with sum[24]=0, and the whole subtract path: sum[24] SHALL be ignored; mantissa=sum[23:0]<<lzc, exponent=ex-lzc, round bit=0.
REQ-022 sum[23:0]==0 on the subtract path SHALL produce +0 (32'h00000000) with flags=3'b001.
REQ-023 Left normalisation with ex<=lzc SHALL flush to signed zero with flags=3'b011; denormals SHALL NOT be produced.
REQ-024 Final exponent >=255 after rounding SHALL produce signed infinity (exp=8'hFF, frac=0) with flags=3'b100.
REQ-025 in_ex==8'hFF SHALL pass through as signed infinity with flags=3'b100.
REQ-026 Rounding carry out of the mantissa SHALL yield mantissa 1.0 and exponent+1, then be rechecked against REQ-024.
REQ-027 out_result SHALL be {sign, exp[7:0], mantissa[22:0]}; the hidden bit SHALL be dropped.

Reset
REQ-028 While RESETn=0: s1_valid, s2_valid and out_valid SHALL be 0; out_result, out_flags and every pipeline register SHALL be 0; in_ready SHALL be 1 immediately after release.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight results; no out_valid SHALL appear for them after release.

Configuration
REQ-030 With macro FA_RNE_ROUND_EN defined, the add path with sum[24]=1 SHALL round to nearest even: increment the mantissa when round&mantissa[0].
REQ-031 Without FA_RNE_ROUND_EN, the round bit SHALL be discarded (truncate); all other behaviour SHALL be identical.

Verification
REQ-032 1.0+1.0: sign=0, ex=127, yn=0, P0/GG encoding sum=25'h1000000 -> out_result=32'h40000000, flags=0, 2 cycles later.
REQ-033 Subtract 1.5-1.25: ex=127, yn=1, sum[23:0]=24'h200000 (lzc=2) -> out_result=32'h3E800000, flags=0.
REQ-034 Subtract with equal operands: sum[23:0]=0 -> 32'h00000000, flags=3'b001; ex=2 with lzc=5 -> signed zero, flags=3'b011.
REQ-035 Add with ex=254 and sum[24]=1 -> 32'h7F800000 (sign 0), flags=3'b100; sum=25'h1FFFFFF with FA_RNE_ROUND_EN -> round carry, exponent+2 over ex.
REQ-036 Back-to-back inputs with out_ready low for 3 cycles -> in_ready falls once both stages are full; no result is lost or duplicated; order is preserved.
REQ-037 RESETn pulsed low with 2 results in flight -> out_valid=0 and outputs=0 during reset; nothing from those results emerges afterwards.
